// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad row scanner.
package keypad_pkg;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Index of the set bit; only meaningful when the argument is one-hot.
  function automatic logic [1:0] onehot4_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer for the raw keypad column lines.
module keypad_col_sync
  import keypad_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [COLS-1:0] d,
  output logic [COLS-1:0] q
);

  logic [COLS-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_row_scan.sv
// Row-driving 4x4 keypad scanner: one-hot row drive, column sampling at slot end,
// single-key debounce with press/release pulses and a held level.
module keypad_row_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1024,
  parameter int unsigned DEB_CNT  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            scan_en,
  input  logic [COLS-1:0] col,
  output logic [ROWS-1:0] row,
  output logic            key_valid,
  output logic [3:0]      key_code,
  output logic            key_down,
  output logic            key_release
);

  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned DW = $clog2(DEB_CNT + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT);

  logic [COLS-1:0] col_s;
  logic [SW-1:0]   slot_cnt;
  logic            en_q;
  logic [ROWS-1:0] row_q;
  logic [1:0]      r_idx;
  logic [1:0]      c_idx;
  logic [DW-1:0]   deb_cnt;
  state_t          state, state_nxt;

  logic            sample;
  logic            new_onehot;
  logic            col_hit;
  logic            latched_open;
  logic [DW-1:0]   deb_inc;
  logic            deb_done;

  logic            rotate;
  logic            capture;
  logic [DW-1:0]   deb_nxt;
  logic            valid_nxt;
  logic            release_nxt;
  logic [3:0]      code_nxt;

  keypad_col_sync u_col_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (col),
    .q     (col_s)
  );

  // en_q is the registered scan_en: it gates the row pins and marks the
  // first enabled cycle, on which the slot is held at 0 so it restarts cleanly.
  assign row          = en_q ? row_q : '0;
  assign sample       = scan_en && en_q && (slot_cnt == SLOT_LAST);
  assign new_onehot   = is_onehot4(col_s);
  assign col_hit      = (col_s == (4'b0001 << c_idx));
  assign latched_open = ~col_s[c_idx];
  assign deb_inc      = deb_cnt + 1'b1;
  assign deb_done     = (deb_inc == DEB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SCAN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!scan_en) begin
      state_nxt = SCAN;
    end else if (sample) begin
      case (state)
        SCAN:    if (new_onehot) state_nxt = (DEB_CNT == 1) ? HOLD : CONFIRM;
        CONFIRM: begin
          if (!col_hit)      state_nxt = SCAN;
          else if (deb_done) state_nxt = HOLD;
        end
        HOLD:    if (latched_open && deb_done) state_nxt = SCAN;
        default: state_nxt = SCAN;
      endcase
    end
  end

  always_comb begin
    rotate      = 1'b0;
    capture     = 1'b0;
    deb_nxt     = deb_cnt;
    valid_nxt   = 1'b0;
    release_nxt = 1'b0;
    if (!scan_en) begin
      deb_nxt = '0;
    end else if (sample) begin
      case (state)
        SCAN: begin
          if (new_onehot) begin
            capture = 1'b1;
            if (DEB_CNT == 1) begin
              valid_nxt = 1'b1;
              deb_nxt   = '0;
            end else begin
              deb_nxt = DW'(1);
            end
          end else begin
            rotate = 1'b1;
          end
        end
        CONFIRM: begin
          if (!col_hit) begin
            rotate  = 1'b1;
            deb_nxt = '0;
          end else if (deb_done) begin
            valid_nxt = 1'b1;
            deb_nxt   = '0;
          end else begin
            deb_nxt = deb_inc;
          end
        end
        HOLD: begin
          if (latched_open) begin
            if (deb_done) begin
              release_nxt = 1'b1;
              rotate      = 1'b1;
              deb_nxt     = '0;
            end else begin
              deb_nxt = deb_inc;
            end
          end else begin
            deb_nxt = '0;
          end
        end
        default: deb_nxt = '0;
      endcase
    end
  end

  // With single-sample debounce the code comes straight from the capture.
  assign code_nxt = capture ? {onehot4_idx(row_q), onehot4_idx(col_s)} : {r_idx, c_idx};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt    <= '0;
      en_q        <= 1'b1;
      row_q       <= 4'b0001;
      r_idx       <= '0;
      c_idx       <= '0;
      deb_cnt     <= '0;
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_down    <= 1'b0;
      key_release <= 1'b0;
    end else begin
      en_q        <= scan_en;
      deb_cnt     <= deb_nxt;
      key_valid   <= valid_nxt;
      key_release <= release_nxt;
      key_down    <= (state_nxt == HOLD);
      if (valid_nxt) key_code <= code_nxt;
      if (capture) begin
        r_idx <= onehot4_idx(row_q);
        c_idx <= onehot4_idx(col_s);
      end
      if (!scan_en) begin
        slot_cnt <= '0;
        row_q    <= 4'b0001;
      end else if (!en_q) begin
        slot_cnt <= '0;
      end else begin
        slot_cnt <= (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + 1'b1;
        if (rotate) row_q <= {row_q[ROWS-2:0], row_q[ROWS-1]};
      end
    end
  end

endmodule
